// File: rtl/mem_access_if.sv
// Byte-wide synchronous RAM port used by the MEM stage.
// Read data follows the address by one clock.
interface mem_access_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport master (
    output mem_a,
    output mem_dout,
    output mem_wr,
    input  mem_din
  );

  modport slave (
    input  mem_a,
    input  mem_dout,
    input  mem_wr,
    output mem_din
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage: serial byte-wide LOAD/STORE with stall to ctrl.
// Non-memory ops pass straight through to mem_wb and forwarding.
module mem_access #(
  parameter int ADDR_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  aluop_i,
  input  logic [2:0]  alufunct3_i,
  input  logic        me_i,
  input  logic [31:0] maddr_i,
  input  logic        wreg_i,
  input  logic [4:0]  wd_i,
  input  logic [31:0] wdata_i,
  mem_access_if.master ram,
  output logic        stallreq_o,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic        wreg_f,
  output logic [4:0]  wd_f,
  output logic [31:0] wdata_f
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE, BUSY, LAST, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ld_q, ld_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wreg_q, wreg_d;
  logic [4:0]        wd_q, wd_d;
  logic [31:0]       data_q, data_d;

  logic        is_ld, is_st, active;
  logic [1:0]  last_idx;
  logic [31:0] ext;
  logic        unused_addr;

  assign is_ld    = aluop_i == OP_LOAD;
  assign is_st    = aluop_i == OP_STORE;
  assign active   = me_i & (is_ld | is_st);
  assign last_idx = f3_q[1] ? 2'd3 : {1'b0, f3_q[0]};
  assign unused_addr = ^maddr_i[31:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wreg_q  <= 1'b0;
      wd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
    end
  end

  // data_q holds store data, or collects load bytes from zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (active) begin
          state_d = BUSY;
          cnt_d   = '0;
          ld_d    = is_ld;
          f3_d    = alufunct3_i;
          addr_d  = maddr_i[ADDR_W-1:0];
          wreg_d  = wreg_i;
          wd_d    = wd_i;
          data_d  = is_ld ? '0 : wdata_i;
        end
      end
      BUSY: begin
        if (ld_q && cnt_q != 2'd0)
          data_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram.mem_din;
        if (cnt_q == last_idx)
          state_d = ld_q ? LAST : DONE;
        else
          cnt_d = cnt_q + 2'd1;
      end
      LAST: begin
        data_d[{last_idx, 3'b000} +: 8] = ram.mem_din;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   ext = {{24{~f3_q[2] & data_q[7]}}, data_q[7:0]};
      2'b01:   ext = {{16{~f3_q[2] & data_q[15]}}, data_q[15:0]};
      default: ext = data_q;
    endcase
  end

  always_comb begin
    stallreq_o   = 1'b0;
    wreg_o       = 1'b0;
    wd_o         = '0;
    wdata_o      = '0;
    ram.mem_a    = '0;
    ram.mem_dout = '0;
    ram.mem_wr   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (active) begin
            stallreq_o = 1'b1;
          end else begin
            wreg_o  = wreg_i;
            wd_o    = wd_i;
            wdata_o = wdata_i;
          end
        end
        BUSY: begin
          stallreq_o = 1'b1;
          ram.mem_a  = addr_q + ADDR_W'(cnt_q);
          if (!ld_q) begin
            ram.mem_wr   = 1'b1;
            ram.mem_dout = data_q[{cnt_q, 3'b000} +: 8];
          end
        end
        LAST: stallreq_o = 1'b1;
        DONE: begin
          if (ld_q) begin
            wreg_o  = wreg_q;
            wd_o    = wd_q;
            wdata_o = ext;
          end
        end
      endcase
    end
  end

  assign wreg_f  = wreg_o;
  assign wd_f    = wd_o;
  assign wdata_f = wdata_o;
endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access with a byte-array RAM
// and an independent byte-level reference memory.
module tb_mem_access;
  localparam int AW = 17;
  localparam int unsigned MSK = (1 << AW) - 1;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  aluop_i = ADD;
  logic [2:0]  alufunct3_i = '0;
  logic        me_i = 1'b0;
  logic [31:0] maddr_i = '0;
  logic        wreg_i = 1'b0;
  logic [4:0]  wd_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stallreq_o, wreg_o, wreg_f;
  logic [4:0]  wd_o, wd_f;
  logic [31:0] wdata_o, wdata_f;

  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(AW)) bus ();

  mem_access #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alufunct3_i(alufunct3_i),
    .me_i       (me_i),
    .maddr_i    (maddr_i),
    .wreg_i     (wreg_i),
    .wd_i       (wd_i),
    .wdata_i    (wdata_i),
    .ram        (bus),
    .stallreq_o (stallreq_o),
    .wreg_o     (wreg_o),
    .wd_o       (wd_o),
    .wdata_o    (wdata_o),
    .wreg_f     (wreg_f),
    .wd_f       (wd_f),
    .wdata_f    (wdata_f)
  );

  logic [7:0] ram  [0:(1<<AW)-1];
  logic [7:0] refm [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a];
  end

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } out_t;

  typedef struct {
    int unsigned a;
    logic [7:0]  b;
  } wr_t;

  out_t oq[$];
  wr_t  wq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    out_t e;
    wr_t  w;
    if (mon_en && !rst) begin
      if (bus.mem_wr) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h at %0t",
                   bus.mem_a, bus.mem_dout, $time);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(bus.mem_a), w.a);
          chk("wr_data", 32'(bus.mem_dout), 32'(w.b));
        end
      end
      if (!stallreq_o) begin
        if (oq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: wd %h wdata %h at %0t",
                   wd_o, wdata_o, $time);
        end else begin
          e = oq.pop_front();
          chk("wreg_o", 32'(wreg_o), 32'(e.wreg));
          chk("wd_o", 32'(wd_o), 32'(e.wd));
          chk("wdata_o", wdata_o, e.wdata);
          chk("wreg_f", 32'(wreg_f), 32'(e.wreg));
          chk("wd_f", 32'(wd_f), 32'(e.wd));
          chk("wdata_f", wdata_f, e.wdata);
          chk("wr_in_done", 32'(bus.mem_wr), 32'd0);
        end
      end
    end
  end

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3,
                       input logic me, input logic [31:0] addr,
                       input logic wr, input logic [4:0] wd,
                       input logic [31:0] wdata);
    int          n, stall_exp, k;
    bit          act, ld;
    int unsigned a;
    longint      v;
    out_t        e;
    ld  = (op == LOAD);
    act = me && (op == LOAD || op == STORE);
    n   = f3[1] ? 4 : (f3[0] ? 2 : 1);
    a   = addr & MSK;
    if (!act) begin
      e = '{wr, wd, wdata};
      stall_exp = 0;
    end else if (!ld) begin
      for (int i = 0; i < n; i++) begin
        wq.push_back('{(a + i) & MSK, wdata[8*i +: 8]});
        refm[(a + i) & MSK] = wdata[8*i +: 8];
      end
      e = '{1'b0, 5'd0, 32'd0};
      stall_exp = n + 1;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v + (longint'(refm[(a + i) & MSK]) << (8 * i));
      if (!f3[2] && v >= (64'sd1 <<< (8 * n - 1)))
        v = v - (64'sd1 <<< (8 * n));
      e = '{wr, wd, v[31:0]};
      stall_exp = n + 2;
    end
    oq.push_back(e);
    aluop_i = op;
    alufunct3_i = f3;
    me_i = me;
    maddr_i = addr;
    wreg_i = wr;
    wd_i = wd;
    wdata_i = wdata;
    mon_en = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (!stallreq_o) break;
      if (act && ld && k >= 1 && k <= n) begin
        chk("ld_addr", 32'(bus.mem_a), (a + k - 1) & MSK);
        chk("ld_nowr", 32'(bus.mem_wr), 32'd0);
      end
      k++;
      if (k > 40) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: still stalled after %0d cycles", k);
        break;
      end
    end
    chk("stall_cycles", k, stall_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 32'(stallreq_o), 0);
    chk({tag, "_wreg"}, 32'(wreg_o), 0);
    chk({tag, "_wd"}, 32'(wd_o), 0);
    chk({tag, "_wdata"}, wdata_o, 0);
    chk({tag, "_wreg_f"}, 32'(wreg_f), 0);
    chk({tag, "_wd_f"}, 32'(wd_f), 0);
    chk({tag, "_wdata_f"}, wdata_f, 0);
    chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
    chk({tag, "_mem_a"}, 32'(bus.mem_a), 0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] hi, a17, base;
    int          kind, r;
    for (int i = 0; i < (1 << AW); i++) begin
      b = 8'($urandom());
      ram[i] = b;
      refm[i] = b;
    end
    wreg_i = 1'b1;
    wd_i = 5'd5;
    wdata_i = 32'd7;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("rst_pass");
    me_i = 1'b1;
    aluop_i = STORE;
    #1;
    chk_zero("rst_store");
    me_i = 1'b0;
    aluop_i = ADD;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    do_op(STORE, 3'b010, 1, 32'h100, 0, 0, 32'hDEADBEEF);
    do_op(STORE, 3'b000, 1, 32'h200, 0, 0, 32'h00000080);
    do_op(LOAD, 3'b000, 1, 32'h200, 1, 5'd3, 0);
    do_op(LOAD, 3'b100, 1, 32'h200, 1, 5'd4, 0);
    do_op(STORE, 3'b000, 1, 32'h203, 0, 0, 32'h01);
    do_op(STORE, 3'b000, 1, 32'h204, 0, 0, 32'h80);
    do_op(LOAD, 3'b001, 1, 32'h203, 1, 5'd6, 0);
    do_op(LOAD, 3'b101, 1, 32'h203, 1, 5'd7, 0);
    do_op(ADD, 3'b000, 0, 0, 1, 5'd5, 32'd7);
    do_op(STORE, 3'b010, 1, 32'h0001FFFF, 0, 0, 32'h12345678);
    do_op(LOAD, 3'b010, 1, 32'hABC1FFFF, 1, 5'd8, 0);
    do_op(LOAD, 3'b000, 1, 32'h0, 0, 0, 0);

    // store aborted by reset during its second byte
    wq.push_back('{32'h40, 8'h44});
    refm[32'h40] = 8'h44;
    aluop_i = STORE;
    alufunct3_i = 3'b010;
    me_i = 1'b1;
    maddr_i = 32'h40;
    wreg_i = 1'b0;
    wd_i = '0;
    wdata_i = 32'h11223344;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("abort");
    mon_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    me_i = 1'b0;
    aluop_i = ADD;
    @(posedge clk);
    #1;
    do_op(ADD, 3'b000, 0, 0, 0, 0, 0);
    do_op(LOAD, 3'b010, 1, 32'h40, 1, 5'd9, 0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      base = ($urandom_range(0, 1) != 0) ? 32'h1FFF8 : 32'h40;
      a17 = (base + $urandom_range(0, 15)) & MSK;
      hi = $urandom();
      if (kind < 2) begin
        r = $urandom_range(0, 2);
        if (r == 0)
          do_op(ADD, 3'($urandom()), 1'($urandom()), hi,
                1'($urandom()), 5'($urandom()), $urandom());
        else
          do_op(r == 1 ? LOAD : STORE, 3'($urandom()), 0, hi,
                1'($urandom()), 5'($urandom()), $urandom());
      end else begin
        do_op(kind < 6 ? STORE : LOAD, 3'($urandom()), 1,
              (hi << AW) | a17, 1'($urandom()), 5'($urandom()),
              $urandom());
      end
    end

    @(negedge clk);
    chk("outq_empty", oq.size(), 0);
    chk("wrq_empty", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
